// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch controller. Drives the program counter register
//   (pc_next / w_pc), runs a level req/ack read handshake towards
//   instruction memory and hands fetched words to decode.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     defined   : ack timeout counter; after MAX_WAIT consecutive cycles in
//                 REQ without ack the request is dropped, fault is set
//                 (sticky until RESET) and the FSM goes to HALT.
//     undefined : REQ waits forever, fault is tied low.
//
//   Ports
//     CLK, RESET           clock (rising edge), async active-high reset
//     start                leave IDLE/HALT, fetch from RESET_VECTOR
//     halt                 stop at next transaction boundary
//     stall                decode cannot accept, hold current instruction
//     redirect, redirect_addr   taken branch/jump and its target
//     imem_ack, imem_rdata memory response
//     imem_req, imem_addr  memory request (level) and address
//     pc_next, w_pc        program counter value and 1-cycle write pulse
//     instr, instr_valid   instruction to decode
//     fault                sticky fetch timeout flag
//     state                FSM state for debug
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | 00: after reset, nothing requested
//   REQ   | 01: imem_req high, waiting for ack at imem_addr
//   HOLD  | 10: decode stalled, instruction held valid, no request
//   HALT  | 11: stopped, only start or RESET leaves

module fetch_sequencer #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
    parameter int unsigned        INC          = 4,
    parameter int unsigned        MAX_WAIT     = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc_next,
    output logic              w_pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              fault,
    output logic [1:0]        state
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic              w_pc_q, w_pc_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              fault_q, fault_d;
    logic              redir_pend_q, redir_pend_d;
    logic [ADDR_W-1:0] redir_addr_q, redir_addr_d;
    logic              halt_pend_q, halt_pend_d;
    logic              halt_eff;
    logic              timeout;

    assign halt_eff = halt | halt_pend_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Down-counter reloaded outside REQ and on every ack; terminal count
    // with no ack marks the MAX_WAIT-th consecutive empty cycle.
    assign timeout = (state_q == S_REQ) && !imem_ack && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != S_REQ) || imem_ack)
            cnt_d = CNT_LOAD;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt_q <= CNT_LOAD;
        else
            cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            pc_next_q     <= '0;
            w_pc_q        <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            redir_pend_q  <= 1'b0;
            redir_addr_q  <= '0;
            halt_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_next_q     <= pc_next_d;
            w_pc_q        <= w_pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            redir_pend_q  <= redir_pend_d;
            redir_addr_q  <= redir_addr_d;
            halt_pend_q   <= halt_pend_d;
        end
    end

    // Next-state logic; priority redirect > halt > stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (halt)
                    state_d = S_HALT;
                else if (start)
                    state_d = S_REQ;
            end
            S_REQ: begin
                if (timeout)
                    state_d = S_HALT;
                else if (imem_ack) begin
                    if (redirect || redir_pend_q)
                        state_d = S_REQ;
                    else if (halt_eff)
                        state_d = S_HALT;
                    else if (stall)
                        state_d = S_HOLD;
                    else
                        state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect)
                    state_d = S_REQ;
                else if (halt_eff)
                    state_d = S_HALT;
                else if (!stall)
                    state_d = S_REQ;
            end
            default: begin
                if (start)
                    state_d = S_REQ;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pc_d          = pc_q;
        pc_next_d     = pc_next_q;
        w_pc_d        = 1'b0;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        fault_d       = fault_q | timeout;
        redir_pend_d  = redir_pend_q;
        redir_addr_d  = redir_addr_q;

        case (state_q)
            S_REQ: begin
                if (timeout) begin
                    redir_pend_d = 1'b0;
                end else if (imem_ack) begin
                    if (redirect) begin
                        // Live redirect beats any older latched target
                        pc_d         = redirect_addr;
                        w_pc_d       = 1'b1;
                        redir_pend_d = 1'b0;
                    end else if (redir_pend_q) begin
                        pc_d         = redir_addr_q;
                        w_pc_d       = 1'b1;
                        redir_pend_d = 1'b0;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + ADDR_W'(INC);
                        w_pc_d        = 1'b1;
                    end
                end else if (redirect) begin
                    // Request cannot be withdrawn; remember target for the ack
                    redir_pend_d = 1'b1;
                    redir_addr_d = redirect_addr;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d   = redirect_addr;
                    w_pc_d = 1'b1;
                end else begin
                    instr_valid_d = (state_d == S_HOLD);
                end
            end
            default: begin
                if (state_d == S_REQ) begin
                    pc_d         = RESET_VECTOR;
                    w_pc_d       = 1'b1;
                    redir_pend_d = 1'b0;
                end
            end
        endcase

        if (w_pc_d)
            pc_next_d = pc_d;

        if (state_d == S_HALT)
            halt_pend_d = 1'b0;
        else
            halt_pend_d = halt_pend_q |
                          (halt && ((state_q == S_REQ) || (state_q == S_HOLD)));

        imem_req_d  = (state_d == S_REQ);
        imem_addr_d = pc_d;
    end

    assign state       = state_q;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign pc_next     = pc_next_q;
    assign w_pc        = w_pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic        halt;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_next;
    logic        w_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;
    logic [1:0]  state;

    int n_pass;
    int n_total;

    fetch_sequencer dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .start         (start),
        .halt          (halt),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc_next       (pc_next),
        .w_pc          (w_pc),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .fault         (fault),
        .state         (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 0; halt = 0; stall = 0; redirect = 0;
        redirect_addr = '0; imem_ack = 0; imem_rdata = '0;
        tick(); tick();
        n_total++;
        if ({state, imem_req, w_pc, instr_valid, fault} !== 6'b0) $display("FAIL reset_ctl: got %b expected 000000", {state, imem_req, w_pc, instr_valid, fault});
        else n_pass++;
        n_total++;
        if ({imem_addr, pc_next, instr} !== 96'h0) $display("FAIL reset_data: got %h expected 0", {imem_addr, pc_next, instr});
        else n_pass++;
        RESET = 1'b0;
        tick();
        n_total++;
        if ({state, imem_req} !== 3'b000) $display("FAIL idle_hold: got %b expected 000", {state, imem_req});
        else n_pass++;
    endtask

    task automatic test_sequential();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if ({state, imem_req, w_pc, pc_next, imem_addr} !== {2'b01, 1'b1, 1'b1, 32'h0, 32'h0}) $display("FAIL start: got st=%b req=%b wpc=%b pcn=%h addr=%h expected 01 1 1 0 0", state, imem_req, w_pc, pc_next, imem_addr);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) $display("FAIL seq_addr%0d: got req=%b addr=%h expected 1 %h", i, imem_req, imem_addr, 4 * i);
            else n_pass++;
            imem_ack = 1'b1;
            imem_rdata = 32'hA0 + 32'(i);
            tick();
            n_total++;
            if ({instr_valid, instr, w_pc, pc_next} !== {1'b1, 32'hA0 + 32'(i), 1'b1, 32'(4 * (i + 1))}) $display("FAIL seq_data%0d: got v=%b i=%h wpc=%b pcn=%h expected 1 %h 1 %h", i, instr_valid, instr, w_pc, pc_next, 32'hA0 + 32'(i), 4 * (i + 1));
            else n_pass++;
        end
        imem_ack = 1'b0;
        tick();
        n_total++;
        if ({instr_valid, w_pc, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 32'd12}) $display("FAIL seq_wait: got v=%b wpc=%b req=%b addr=%h expected 0 0 1 c", instr_valid, w_pc, imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect();
        redirect = 1'b1;
        redirect_addr = 32'h100;
        tick();
        redirect = 1'b0;
        n_total++;
        if ({imem_req, imem_addr, w_pc, instr_valid} !== {1'b1, 32'd12, 1'b0, 1'b0}) $display("FAIL redir_latch: got req=%b addr=%h wpc=%b v=%b expected 1 c 0 0", imem_req, imem_addr, w_pc, instr_valid);
        else n_pass++;
        tick(); tick();
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD;
        tick();
        imem_ack = 1'b0;
        n_total++;
        if ({instr_valid, instr, w_pc, pc_next, imem_addr} !== {1'b0, 32'hA2, 1'b1, 32'h100, 32'h100}) $display("FAIL redir_ack: got v=%b i=%h wpc=%b pcn=%h addr=%h expected 0 a2 1 100 100", instr_valid, instr, w_pc, pc_next, imem_addr);
        else n_pass++;
        imem_ack = 1'b1;
        imem_rdata = 32'hB0;
        tick();
        n_total++;
        if ({instr_valid, instr, pc_next, imem_addr} !== {1'b1, 32'hB0, 32'h104, 32'h104}) $display("FAIL redir_target: got v=%b i=%h pcn=%h addr=%h expected 1 b0 104 104", instr_valid, instr, pc_next, imem_addr);
        else n_pass++;
        redirect = 1'b1;
        redirect_addr = 32'h200;
        imem_rdata = 32'hBAD;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b0;
        n_total++;
        if ({instr_valid, w_pc, pc_next, imem_addr, state} !== {1'b0, 1'b1, 32'h200, 32'h200, 2'b01}) $display("FAIL redir_same: got v=%b wpc=%b pcn=%h addr=%h st=%b expected 0 1 200 200 01", instr_valid, w_pc, pc_next, imem_addr, state);
        else n_pass++;
    endtask

    task automatic test_stall();
        imem_ack = 1'b1;
        imem_rdata = 32'hC0;
        stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_total++;
        if ({state, imem_req, instr_valid, instr, pc_next} !== {2'b10, 1'b0, 1'b1, 32'hC0, 32'h204}) $display("FAIL stall_enter: got st=%b req=%b v=%b i=%h pcn=%h expected 10 0 1 c0 204", state, imem_req, instr_valid, instr, pc_next);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({state, imem_req, instr_valid, instr, w_pc} !== {2'b10, 1'b0, 1'b1, 32'hC0, 1'b0}) $display("FAIL stall_hold%0d: got st=%b req=%b v=%b i=%h wpc=%b expected 10 0 1 c0 0", i, state, imem_req, instr_valid, instr, w_pc);
            else n_pass++;
        end
        stall = 1'b0;
        tick();
        n_total++;
        if ({state, imem_req, imem_addr, instr_valid} !== {2'b01, 1'b1, 32'h204, 1'b0}) $display("FAIL stall_exit: got st=%b req=%b addr=%h v=%b expected 01 1 204 0", state, imem_req, imem_addr, instr_valid);
        else n_pass++;
        imem_ack = 1'b1;
        imem_rdata = 32'hC1;
        stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'h300;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        n_total++;
        if ({state, imem_req, instr_valid, w_pc, pc_next, imem_addr} !== {2'b01, 1'b1, 1'b0, 1'b1, 32'h300, 32'h300}) $display("FAIL hold_redir: got st=%b req=%b v=%b wpc=%b pcn=%h addr=%h expected 01 1 0 1 300 300", state, imem_req, instr_valid, w_pc, pc_next, imem_addr);
        else n_pass++;
    endtask

    task automatic test_halt_restart();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        n_total++;
        if ({state, imem_req} !== 3'b011) $display("FAIL halt_wait: got st=%b req=%b expected 01 1", state, imem_req);
        else n_pass++;
        imem_ack = 1'b1;
        imem_rdata = 32'hD0;
        tick();
        imem_ack = 1'b0;
        n_total++;
        if ({state, imem_req, instr_valid, instr, pc_next} !== {2'b11, 1'b0, 1'b1, 32'hD0, 32'h304}) $display("FAIL halt_deliver: got st=%b req=%b v=%b i=%h pcn=%h expected 11 0 1 d0 304", state, imem_req, instr_valid, instr, pc_next);
        else n_pass++;
        redirect = 1'b1;
        redirect_addr = 32'h400;
        tick(); tick();
        redirect = 1'b0;
        n_total++;
        if ({state, imem_req, instr_valid, w_pc, pc_next} !== {2'b11, 1'b0, 1'b0, 1'b0, 32'h304}) $display("FAIL halt_stay: got st=%b req=%b v=%b wpc=%b pcn=%h expected 11 0 0 0 304", state, imem_req, instr_valid, w_pc, pc_next);
        else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if ({state, imem_req, imem_addr, w_pc, pc_next} !== {2'b01, 1'b1, 32'h0, 1'b1, 32'h0}) $display("FAIL restart: got st=%b req=%b addr=%h wpc=%b pcn=%h expected 01 1 0 1 0", state, imem_req, imem_addr, w_pc, pc_next);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b1;
        imem_rdata = 32'hE0;
        tick();
        imem_ack = 1'b0;
        n_total++;
        if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b1, 32'h4}) $display("FAIL pre_reset: got req=%b v=%b addr=%h expected 1 1 4", imem_req, instr_valid, imem_addr);
        else n_pass++;
        #1;
        RESET = 1'b1;
        #1;
        n_total++;
        if ({state, imem_req, w_pc, instr_valid, fault, imem_addr, pc_next, instr} !== 102'h0) $display("FAIL async_reset: got st=%b req=%b wpc=%b v=%b f=%b addr=%h pcn=%h i=%h expected all 0", state, imem_req, w_pc, instr_valid, fault, imem_addr, pc_next, instr);
        else n_pass++;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick();
        n_total++;
        if ({state, imem_req, fault} !== 4'b0110) $display("FAIL to_before: got st=%b req=%b f=%b expected 01 1 0", state, imem_req, fault);
        else n_pass++;
        tick();
        n_total++;
        if ({state, imem_req, fault} !== 4'b1101) $display("FAIL to_expire: got st=%b req=%b f=%b expected 11 0 1", state, imem_req, fault);
        else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if ({state, imem_req, fault} !== 4'b0111) $display("FAIL to_sticky: got st=%b req=%b f=%b expected 01 1 1", state, imem_req, fault);
        else n_pass++;
`else
        for (int i = 0; i < 100; i++) tick();
        n_total++;
        if ({state, imem_req, fault} !== 4'b0110) $display("FAIL no_timeout: got st=%b req=%b f=%b expected 01 1 0", state, imem_req, fault);
        else n_pass++;
`endif
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_halt_restart();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
